soc_uart_fifo: RTL and testbench

SOC_UART_FIFO -- requirements
Module: soc_uart_fifo

---
 rtl/soc_uart_pkg.sv | 20 ++
 rtl/soc_uart_fifo_buf.sv | 55 +++++
 rtl/soc_uart_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_soc_uart_fifo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/soc_uart_pkg.sv
// rtl/soc_uart_pkg.sv - shared types and constants for the 16x-oversampled UART with FIFOs
package soc_uart_pkg;

   typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

   typedef enum logic [2:0] {
      RX_WAITING, RX_WAITSTART, RX_DATA, RX_PARITY, RX_WAITSTOP, RX_BREAK
   } rx_state_t;

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

   localparam int unsigned SUBBITS = 16;
   localparam int unsigned BIDXW   = 3;

   // Parity bit that completes the frame: even -> total ones even, odd -> total ones odd.
   function automatic logic par_fill(input logic ones_odd, input parity_t mode);
      return (mode == PAR_ODD) ? ~ones_odd : ones_odd;
   endfunction

endpackage

// File: rtl/soc_uart_fifo_buf.sv
// rtl/soc_uart_fifo_buf.sv - circular FIFO; push on full is accepted only together with a pop
module soc_uart_fifo_buf #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q, cnt_d;
   logic             push_eff, pop_eff;

   assign empty_o  = (cnt_q == '0);
   assign full_o   = (cnt_q == (AW+1)'(DEPTH));
   assign level_o  = cnt_q;
   assign head_o   = mem_q[rd_q];
   assign pop_eff  = pop_i && !empty_o;
   assign push_eff = push_i && (!full_o || pop_eff);

   always_comb begin
      cnt_d = cnt_q;
      case ({push_eff, pop_eff})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_eff) wr_q <= wr_q + AW'(1);
         if (pop_eff)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_eff) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/soc_uart_fifo.sv
// rtl/soc_uart_fifo.sv - UART RX/TX engines on a shared 16x sub-bit counter, each backed by a FIFO
module soc_uart_fifo
   import soc_uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter parity_t     PARITY    = PAR_NONE,
   parameter int unsigned RX_DEPTH  = 4,
   parameter int unsigned TX_DEPTH  = 4
) (
   input  logic                        uclk,
   input  logic                        res,
   input  logic                        uart_rx,
   output logic                        uart_tx,
   output logic                        rx_valid,
   output logic [DATA_BITS-1:0]        rx_data,
   input  logic                        rx_pop,
   output logic [$clog2(RX_DEPTH):0]   rx_level,
   output logic                        tx_ready,
   input  logic [DATA_BITS-1:0]        tx_data,
   input  logic                        tx_push,
   output logic                        tx_idle,
   output logic                        rx_overrun,
   output logic                        rx_break,
   output logic                        rx_parity_err,
   input  logic                        ack
);
   localparam int unsigned     CNTW = $clog2(SUBBITS);
   localparam logic [CNTW-1:0] HALF = CNTW'(SUBBITS / 2);
   localparam logic [BIDXW-1:0] LAST = BIDXW'(DATA_BITS - 1);

   logic [CNTW-1:0] cnt_q, cnt_d;
   assign cnt_d = cnt_q + CNTW'(1);

   always_ff @(posedge uclk) begin
      if (res) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   rx_state_t            rx_state_q;
   logic [CNTW-1:0]      rx_samp_q;
   logic [BIDXW-1:0]     rx_idx_q;
   logic [DATA_BITS-1:0] rx_shift_q;
   logic                 rx_par_q;
   logic                 rx_at_samp, rx_stop_ok, rx_push, rx_pop_eff, rx_full, rx_empty;
   logic                 ovr_set, brk_set, perr_set;
   logic                 ovr_q, brk_q, perr_q;

   assign rx_at_samp = (cnt_q == rx_samp_q);
   assign rx_stop_ok = (rx_state_q == RX_WAITSTOP) && rx_at_samp && uart_rx;
   assign rx_pop_eff = rx_pop && !rx_empty;
   assign rx_push    = rx_stop_ok && (!rx_full || rx_pop_eff);
   assign ovr_set    = rx_stop_ok && rx_full && !rx_pop_eff;
   assign brk_set    = (rx_state_q == RX_WAITSTOP) && rx_at_samp && !uart_rx;
   assign perr_set   = rx_stop_ok && (PARITY != PAR_NONE)
                       && (rx_par_q != par_fill(^rx_shift_q, PARITY));

   // Data bits shift in from the top so the first (LSB) bit lands at bit 0 after DATA_BITS shifts.
   always_ff @(posedge uclk) begin
      if (res) begin
         rx_state_q <= RX_WAITING;
         rx_samp_q  <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
      end else begin
         case (rx_state_q)
            RX_WAITING: if (!uart_rx) begin
               rx_samp_q  <= cnt_q + HALF;
               rx_state_q <= RX_WAITSTART;
            end
            RX_WAITSTART: begin
               if (uart_rx) rx_state_q <= RX_WAITING;
               else if (rx_at_samp) begin
                  rx_idx_q   <= '0;
                  rx_state_q <= RX_DATA;
               end
            end
            RX_DATA: if (rx_at_samp) begin
               rx_shift_q <= {uart_rx, rx_shift_q[DATA_BITS-1:1]};
               rx_idx_q   <= rx_idx_q + BIDXW'(1);
               if (rx_idx_q == LAST)
                  rx_state_q <= (PARITY != PAR_NONE) ? RX_PARITY : RX_WAITSTOP;
            end
            RX_PARITY: if (rx_at_samp) begin
               rx_par_q   <= uart_rx;
               rx_state_q <= RX_WAITSTOP;
            end
            RX_WAITSTOP: if (rx_at_samp) rx_state_q <= uart_rx ? RX_WAITING : RX_BREAK;
            RX_BREAK:    if (uart_rx) rx_state_q <= RX_WAITING;
            default:     rx_state_q <= RX_WAITING;
         endcase
      end
   end

   always_ff @(posedge uclk) begin
      if (res) begin
         ovr_q  <= 1'b0;
         brk_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         ovr_q  <= ovr_set  | (ovr_q  & ~ack);
         brk_q  <= brk_set  | (brk_q  & ~ack);
         perr_q <= perr_set | (perr_q & ~ack);
      end
   end

   assign rx_overrun    = ovr_q;
   assign rx_break      = brk_q;
   assign rx_parity_err = perr_q;
   assign rx_valid      = !rx_empty;

   soc_uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk_i   (uclk),
      .rst_i   (res),
      .push_i  (rx_push),
      .data_i  (rx_shift_q),
      .pop_i   (rx_pop),
      .head_o  (rx_data),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .level_o (rx_level)
   );

   tx_state_t                   tx_state_q;
   logic [CNTW-1:0]             tx_edge_q;
   logic [BIDXW-1:0]            tx_idx_q;
   logic [DATA_BITS-1:0]        tx_shift_q, tx_head;
   logic                        tx_par_q, tx_q, tx_bit;
   logic                        tx_at_edge, tx_pre_edge, tx_pop, tx_full, tx_empty;
   logic [$clog2(TX_DEPTH):0]   tx_level;

   assign tx_at_edge  = (cnt_q == tx_edge_q);
   assign tx_pre_edge = (cnt_d == tx_edge_q);
   assign tx_pop      = !tx_empty && ((tx_state_q == TX_IDLE)
                        || ((tx_state_q == TX_STOP) && tx_pre_edge));

   always_comb begin
      tx_bit = 1'b1;
      case (tx_state_q)
         TX_START:  tx_bit = 1'b0;
         TX_DATA:   tx_bit = tx_shift_q[0];
         TX_PARITY: tx_bit = tx_par_q;
         default:   tx_bit = 1'b1;
      endcase
   end

   // Line changes only at the edge point; state moves one cycle earlier so each bit holds 16 uclk.
   always_ff @(posedge uclk) begin
      if (res) begin
         tx_state_q <= TX_IDLE;
         tx_edge_q  <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         if (tx_state_q == TX_IDLE) tx_q <= 1'b1;
         else if (tx_at_edge)       tx_q <= tx_bit;
         case (tx_state_q)
            TX_IDLE: if (!tx_empty) begin
               tx_edge_q  <= cnt_d;
               tx_state_q <= TX_START;
            end
            TX_START: if (tx_pre_edge) tx_state_q <= TX_DATA;
            TX_DATA: if (tx_pre_edge) begin
               if (tx_idx_q == LAST)
                  tx_state_q <= (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
               else begin
                  tx_shift_q <= tx_shift_q >> 1;
                  tx_idx_q   <= tx_idx_q + BIDXW'(1);
               end
            end
            TX_PARITY: if (tx_pre_edge) tx_state_q <= TX_STOP;
            TX_STOP:   if (tx_pre_edge) tx_state_q <= tx_empty ? TX_IDLE : TX_START;
            default:   tx_state_q <= TX_IDLE;
         endcase
         if (tx_pop) begin
            tx_shift_q <= tx_head;
            tx_par_q   <= par_fill(^tx_head, PARITY);
            tx_idx_q   <= '0;
         end
      end
   end

   assign uart_tx  = tx_q;
   assign tx_ready = !tx_full;
   assign tx_idle  = (tx_state_q == TX_IDLE) && (tx_level == '0);

   soc_uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk_i   (uclk),
      .rst_i   (res),
      .push_i  (tx_push && !tx_full),
      .data_i  (tx_data),
      .pop_i   (tx_pop),
      .head_o  (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .level_o (tx_level)
   );

endmodule

// File: tb/tb_soc_uart_fifo.sv
// tb/tb_soc_uart_fifo.sv - directed bench: 8N1 default instance and a 7E1 instance
module tb_soc_uart_fifo;
   import soc_uart_pkg::*;

   logic       uclk, res;
   logic       rx8, tx8, rxv8, pop8, txr8, push8, idle8, ovr8, brk8, perr8, ack8;
   logic [7:0] rxd8, txd8;
   logic [2:0] lvl8;
   logic       rx7, tx7, rxv7, pop7, txr7, push7, idle7, ovr7, brk7, perr7, ack7;
   logic [6:0] rxd7, txd7;
   logic [2:0] lvl7;

   int total = 0;
   int bad   = 0;
   int n;
   logic [19:0] exp_bits;

   soc_uart_fifo u8 (
      .uclk(uclk), .res(res), .uart_rx(rx8), .uart_tx(tx8), .rx_valid(rxv8), .rx_data(rxd8),
      .rx_pop(pop8), .rx_level(lvl8), .tx_ready(txr8), .tx_data(txd8), .tx_push(push8),
      .tx_idle(idle8), .rx_overrun(ovr8), .rx_break(brk8), .rx_parity_err(perr8), .ack(ack8)
   );

   soc_uart_fifo #(.DATA_BITS(7), .PARITY(PAR_EVEN)) u7 (
      .uclk(uclk), .res(res), .uart_rx(rx7), .uart_tx(tx7), .rx_valid(rxv7), .rx_data(rxd7),
      .rx_pop(pop7), .rx_level(lvl7), .tx_ready(txr7), .tx_data(txd7), .tx_push(push7),
      .tx_idle(idle7), .rx_overrun(ovr7), .rx_break(brk7), .rx_parity_err(perr7), .ack(ack7)
   );

   initial uclk = 1'b0;
   always #5 uclk = ~uclk;

   task automatic tick(input int cycles);
      repeat (cycles) @(negedge uclk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit to7, input logic v, input int cycles);
      if (to7) rx7 = v;
      else     rx8 = v;
      tick(cycles);
   endtask

   task automatic send_frame(input bit to7, input logic [7:0] d, input logic par, input logic stop);
      drive(to7, 1'b0, 16);
      for (int i = 0; i < (to7 ? 7 : 8); i++) drive(to7, d[i], 16);
      if (to7) drive(to7, par, 16);
      drive(to7, stop, 16);
   endtask

   task automatic pulse_pop(input bit to7);
      if (to7) pop7 = 1'b1; else pop8 = 1'b1;
      tick(1);
      pop7 = 1'b0;
      pop8 = 1'b0;
   endtask

   task automatic pulse_ack(input bit to7);
      if (to7) ack7 = 1'b1; else ack8 = 1'b1;
      tick(1);
      ack7 = 1'b0;
      ack8 = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      res = 1'b1;
      rx8 = 1'b1; pop8 = 1'b0; push8 = 1'b0; txd8 = '0; ack8 = 1'b0;
      rx7 = 1'b1; pop7 = 1'b0; push7 = 1'b0; txd7 = '0; ack7 = 1'b0;
      tick(3);
      check("rst_tx8",    32'(tx8),   32'd1);
      check("rst_rxv8",   32'(rxv8),  32'd0);
      check("rst_lvl8",   32'(lvl8),  32'd0);
      check("rst_txr8",   32'(txr8),  32'd1);
      check("rst_idle8",  32'(idle8), 32'd1);
      check("rst_ovr8",   32'(ovr8),  32'd0);
      check("rst_brk8",   32'(brk8),  32'd0);
      check("rst_perr8",  32'(perr8), 32'd0);
      check("rst_tx7",    32'(tx7),   32'd1);
      check("rst_rxv7",   32'(rxv7),  32'd0);
      check("rst_lvl7",   32'(lvl7),  32'd0);
      check("rst_txr7",   32'(txr7),  32'd1);
      check("rst_idle7",  32'(idle7), 32'd1);
      check("rst_flags7", 32'({ovr7, brk7, perr7}), 32'd0);
      res = 1'b0;
      tick(2);

      // Two back-to-back words: 20 contiguous bit times, sampled mid-bit.
      exp_bits = {1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0};
      txd8 = 8'h55; push8 = 1'b1;
      tick(1);
      txd8 = 8'hA3;
      tick(1);
      push8 = 1'b0;
      n = 0;
      while (tx8 !== 1'b0 && n < 64) begin
         tick(1);
         n++;
      end
      check("tx_start_seen", 32'(tx8), 32'd0);
      tick(8);
      for (int i = 0; i < 20; i++) begin
         check($sformatf("tx_bit%0d", i), 32'(tx8), 32'(exp_bits[i]));
         if (i < 19) tick(16);
      end
      tick(10);
      check("tx_idle_after", 32'(idle8), 32'd1);
      check("tx_line_after", 32'(tx8),   32'd1);

      // 0x41 has two ones, so the even-parity bit is 0.
      send_frame(1'b1, 8'h41, 1'b0, 1'b1);
      tick(2);
      check("par_ok_valid", 32'(rxv7),  32'd1);
      check("par_ok_data",  32'(rxd7),  32'h41);
      check("par_ok_lvl",   32'(lvl7),  32'd1);
      check("par_ok_err",   32'(perr7), 32'd0);
      pulse_pop(1'b1);
      send_frame(1'b1, 8'h41, 1'b1, 1'b1);
      tick(2);
      check("par_bad_valid", 32'(rxv7),  32'd1);
      check("par_bad_data",  32'(rxd7),  32'h41);
      check("par_bad_err",   32'(perr7), 32'd1);
      tick(5);
      check("par_err_sticky", 32'(perr7), 32'd1);
      pulse_ack(1'b1);
      check("par_err_acked", 32'(perr7), 32'd0);
      pulse_pop(1'b1);
      check("par_drained", 32'(rxv7), 32'd0);

      for (int i = 1; i <= 5; i++) begin
         send_frame(1'b0, 8'(i), 1'b0, 1'b1);
         tick(2);
      end
      check("ovr_lvl",  32'(lvl8), 32'd4);
      check("ovr_flag", 32'(ovr8), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("ovr_pop%0d", i), 32'(rxd8), 32'(i));
         pulse_pop(1'b0);
      end
      check("ovr_empty", 32'(rxv8), 32'd0);
      pulse_ack(1'b0);
      check("ovr_acked", 32'(ovr8), 32'd0);

      send_frame(1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 39 * 16);
      check("brk_flag", 32'(brk8), 32'd1);
      check("brk_lvl",  32'(lvl8), 32'd0);
      drive(1'b0, 1'b1, 32);
      send_frame(1'b0, 8'h7E, 1'b0, 1'b1);
      tick(2);
      check("brk_next_valid", 32'(rxv8), 32'd1);
      check("brk_next_data",  32'(rxd8), 32'h7E);
      check("brk_sticky",     32'(brk8), 32'd1);
      pulse_pop(1'b0);
      pulse_ack(1'b0);
      check("brk_acked", 32'(brk8), 32'd0);

      drive(1'b0, 1'b0, 4);
      drive(1'b0, 1'b1, 40);
      check("glitch_valid", 32'(rxv8), 32'd0);
      check("glitch_lvl",   32'(lvl8), 32'd0);
      check("glitch_state", 32'(u8.rx_state_q), 32'(RX_WAITING));

      // 0x3C: bit 1 (a zero) is on the line about 40 cycles after the push.
      txd8 = 8'h3C; push8 = 1'b1;
      tick(1);
      push8 = 1'b0;
      tick(40);
      check("midtx_line", 32'(tx8),   32'd0);
      check("midtx_busy", 32'(idle8), 32'd0);
      res = 1'b1;
      tick(1);
      check("midtx_rst_line", 32'(tx8),   32'd1);
      check("midtx_rst_idle", 32'(idle8), 32'd1);
      res = 1'b0;
      tick(40);
      check("midtx_quiet", 32'(tx8), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
